conv_out_streamer: RTL and testbench

Downstream stage of the convolution layer. It absorbs the layer's valid-only 64-bit output stream (8 × INT8 per beat, no backpressure) into an elastic FIFO. It re-emits the data as an AXI-Stream master with tready backpressure and TLAST on the final beat of the layer. It also exports almost_full so the top level can gate pixel_valid into the layer before in-flight results overflow the buffer.

---
 rtl/conv_out_streamer.sv | 153 +++++++++++++++
 tb/tb_conv_out_streamer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_streamer.sv
// conv_out_streamer: elastic buffer between the conv layer's valid-only result
// stream and an AXI-Stream master with backpressure, TLAST and almost_full.
// Storage is a RAM with a one-cycle read, a prefetch register and the output
// register, all counted together in fill_level.
// Optional macro OSTREAM_PERF_CNT_EN adds stall_cycles and peak_fill outputs.
module conv_out_streamer #(
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned AFULL_MARGIN = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [31:0]                cfg_total_beats,
  input  logic [63:0]                in_data,
  input  logic                       in_valid,
  output logic                       almost_full,
  output logic [63:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
`ifdef OSTREAM_PERF_CNT_EN
  output logic [31:0]                stall_cycles,
  output logic [$clog2(DEPTH):0]     peak_fill,
`endif
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, ram_cnt;
  logic            q_valid;
  logic [63:0]     q_data;
  logic [31:0]     total, in_cnt, out_cnt;

  logic            hs, beat_ok, full, push, drop;
  logic            out_free, q_take, q_free, rd_en;
  logic            byp_out, byp_q, wr_en, out_load;
  logic [31:0]     load_idx;

  // Occupancy flags derive straight from the registered count
  assign fill_level  = count;
  assign almost_full = (count >= CW'(DEPTH - AFULL_MARGIN));

  // Datapath steering: bypass into the output or prefetch stage when the
  // stages behind it are empty, otherwise write the RAM
  always_comb begin
    hs       = m_axis_tvalid & m_axis_tready;
    beat_ok  = (state == S_RUN) & in_valid & (in_cnt < total);
    full     = (count == CW'(DEPTH));
    push     = beat_ok & (~full | hs);
    drop     = beat_ok & full & ~hs;
    out_free = ~m_axis_tvalid | m_axis_tready;
    q_take   = out_free & q_valid;
    q_free   = ~q_valid | q_take;
    rd_en    = q_free & (ram_cnt != '0);
    byp_out  = push & out_free & ~q_valid & (ram_cnt == '0);
    byp_q    = push & ~byp_out & q_free & (ram_cnt == '0);
    wr_en    = push & ~byp_out & ~byp_q;
    out_load = q_take | byp_out;
    load_idx = hs ? (out_cnt + 32'd1) : out_cnt;
  end

  // RAM write port and one-cycle read into the prefetch register
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
    if (rd_en) q_data <= mem[rd_ptr];
    else if (byp_q) q_data <= in_data;
  end

  // Control state, pointers, counters and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ram_cnt       <= '0;
      q_valid       <= 1'b0;
      total         <= '0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      overflow      <= 1'b0;
      done          <= 1'b0;
`ifdef OSTREAM_PERF_CNT_EN
      stall_cycles  <= '0;
      peak_fill     <= '0;
`endif
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      ram_cnt <= ram_cnt + CW'(wr_en) - CW'(rd_en);
      count   <= count + CW'(push) - CW'(hs);

      if (rd_en | byp_q) q_valid <= 1'b1;
      else if (q_take)   q_valid <= 1'b0;

      if (out_load) begin
        m_axis_tdata  <= q_valid ? q_data : in_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (load_idx == total - 32'd1);
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (hs)      out_cnt  <= out_cnt + 32'd1;
      if (beat_ok) in_cnt   <= in_cnt + 32'd1;
      if (drop)    overflow <= 1'b1;

`ifdef OSTREAM_PERF_CNT_EN
      if ((state == S_RUN) && m_axis_tvalid && !m_axis_tready)
        stall_cycles <= stall_cycles + 32'd1;
      if (count > peak_fill) peak_fill <= count;
`endif

      case (state)
        S_IDLE, S_DONE: begin
          if (cfg_start) begin
            total    <= cfg_total_beats;
            in_cnt   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
            done     <= (cfg_total_beats == 32'd0);
            state    <= (cfg_total_beats == 32'd0) ? S_DONE : S_RUN;
`ifdef OSTREAM_PERF_CNT_EN
            stall_cycles <= '0;
            peak_fill    <= '0;
`endif
          end
        end
        S_RUN: begin
          if (hs && m_axis_tlast) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_streamer.sv
// tb_conv_out_streamer: directed scenarios with a scoreboard of expected beats
// checked on every downstream handshake.
module tb_conv_out_streamer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFM   = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [31:0]   cfg_total_beats;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          almost_full;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [CW-1:0] fill_level;
  logic          overflow;
  logic          done;
`ifdef OSTREAM_PERF_CNT_EN
  logic [31:0]   stall_cycles;
  logic [CW-1:0] peak_fill;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  conv_out_streamer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_total_beats (cfg_total_beats),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .almost_full     (almost_full),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .fill_level      (fill_level),
    .overflow        (overflow),
`ifdef OSTREAM_PERF_CNT_EN
    .stall_cycles    (stall_cycles),
    .peak_fill       (peak_fill),
`endif
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {8{b}};
  endfunction

  // Drive one in_valid beat; record it in the scoreboard when it must be kept
  task automatic push_beat(input logic [63:0] d, input bit keep, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    if (keep) sb.push_back({d, last});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start(input logic [31:0] n);
    cfg_start       = 1'b1;
    cfg_total_beats = n;
    tick();
    cfg_start       = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done !== 1'b1; i++) tick();
    chk("done_reached", 64'(done), 64'd1);
  endtask

  // Scoreboard: each handshake pops the oldest expected beat
  always @(negedge clk) begin
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL extra_beat observed=%0h expected=none", m_axis_tdata);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_data", m_axis_tdata, e.data);
        chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
      end
    end
  end

  initial begin
    rst             = 1'b1;
    cfg_start       = 1'b0;
    cfg_total_beats = '0;
    in_data         = '0;
    in_valid        = 1'b0;
    m_axis_tready   = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_fill",   64'(fill_level),    64'd0);
    chk("rst_done",   64'(done),          64'd0);
    chk("rst_ovf",    64'(overflow),      64'd0);
    chk("rst_afull",  64'(almost_full),   64'd0);

    // 1: four beats streamed straight through
    m_axis_tready = 1'b1;
    start(32'd4);
    push_beat({8{8'h11}}, 1'b1, 1'b0);
    chk("s1_first_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("s1_first_tdata",  m_axis_tdata, {8{8'h11}});
    push_beat({8{8'h22}}, 1'b1, 1'b0);
    push_beat({8{8'h33}}, 1'b1, 1'b0);
    push_beat({8{8'h44}}, 1'b1, 1'b1);
    chk("s1_done_early", 64'(done), 64'd0);
    tick();
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_fill", 64'(fill_level), 64'd0);
    chk("s1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: eight beats buffered under backpressure, then drained
    m_axis_tready = 1'b0;
    start(32'd8);
    for (int k = 0; k < 8; k++) push_beat(pat(8'h50 + k), 1'b1, k == 7);
    repeat (12) tick();
    chk("s2_fill",   64'(fill_level),    64'd8);
    chk("s2_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("s2_tdata",  m_axis_tdata,       pat(8'h50));
    chk("s2_tlast",  64'(m_axis_tlast),  64'd0);
    chk("s2_afull",  64'(almost_full),   64'd0);
`ifdef OSTREAM_PERF_CNT_EN
    chk("s2_peak",   64'(peak_fill),     64'd8);
`endif
    m_axis_tready = 1'b1;
    wait_done(40);
    chk("s2_fill_end", 64'(fill_level), 64'd0);

    // 3: overflow drops beats 17..20, final beat never appears
    m_axis_tready = 1'b0;
    start(32'd20);
    for (int k = 0; k < 20; k++) begin
      push_beat(pat(8'h80 + k), k < 16, 1'b0);
      if (k == 10) begin
        chk("s3_fill11",  64'(fill_level),  64'd11);
        chk("s3_afull11", 64'(almost_full), 64'd0);
      end
      if (k == 11) begin
        chk("s3_fill12",  64'(fill_level),  64'd12);
        chk("s3_afull12", 64'(almost_full), 64'd1);
      end
      if (k == 15) begin
        chk("s3_fill16", 64'(fill_level), 64'd16);
        chk("s3_ovf16",  64'(overflow),   64'd0);
      end
      if (k == 16) chk("s3_ovf17", 64'(overflow), 64'd1);
    end
    chk("s3_fill_full", 64'(fill_level), 64'd16);
    m_axis_tready = 1'b1;
    repeat (30) tick();
    chk("s3_done",     64'(done),          64'd0);
    chk("s3_fill_end", 64'(fill_level),    64'd0);
    chk("s3_tvalid",   64'(m_axis_tvalid), 64'd0);
    chk("s3_ovf_end",  64'(overflow),      64'd1);
    chk("s3_sb_empty", 64'(sb.size()),     64'd0);

    // 4: push and pop together while full
    m_axis_tready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s4_rst_ovf",  64'(overflow),   64'd0);
    chk("s4_rst_fill", 64'(fill_level), 64'd0);
    start(32'd20);
    for (int k = 0; k < 16; k++) push_beat(pat(8'hA0 + k), 1'b1, 1'b0);
    chk("s4_full", 64'(fill_level), 64'd16);
    m_axis_tready = 1'b1;
    push_beat(pat(8'hA0 + 16), 1'b1, 1'b0);
    m_axis_tready = 1'b0;
    chk("s4_fill_same", 64'(fill_level), 64'd16);
    chk("s4_ovf",       64'(overflow),   64'd0);
    m_axis_tready = 1'b1;
    for (int k = 17; k < 20; k++) push_beat(pat(8'hA0 + k), 1'b1, k == 19);
    wait_done(60);
    chk("s4_ovf_end",  64'(overflow),   64'd0);
    chk("s4_fill_end", 64'(fill_level), 64'd0);

    // 5: empty layer completes at once, stray input ignored
    start(32'd0);
    chk("s5_done", 64'(done), 64'd1);
    for (int k = 0; k < 3; k++) begin
      push_beat(pat(8'hC0 + k), 1'b0, 1'b0);
      chk("s5_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("s5_fill",   64'(fill_level),    64'd0);
      chk("s5_ovf",    64'(overflow),      64'd0);
    end

    // 6: reset mid-layer flushes, next layer runs cleanly
    m_axis_tready = 1'b0;
    start(32'd8);
    for (int k = 0; k < 5; k++) push_beat(pat(8'hD0 + k), 1'b1, 1'b0);
    chk("s6_fill5", 64'(fill_level), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("s6_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("s6_fill",   64'(fill_level),    64'd0);
    chk("s6_done",   64'(done),          64'd0);
    m_axis_tready = 1'b1;
    start(32'd2);
    push_beat(pat(8'hE0), 1'b1, 1'b0);
    push_beat(pat(8'hE1), 1'b1, 1'b1);
    wait_done(20);
    chk("s6_fill_end", 64'(fill_level), 64'd0);
    chk("s6_sb_empty", 64'(sb.size()),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
